syncvar_pipe: RTL and testbench

//  Parametrised successor of the 2-bit registered AND/parity block. Combines two

---
 rtl/syncvar_pipe.sv | 69 ++++++
 tb/tb_syncvar_pipe.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/syncvar_pipe.sv
// Bitwise AND/OR/XOR/NAND of two operands carried through a valid-tagged pipeline,
// with output parity and a saturating count of odd-parity results.
module syncvar_pipe #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [1:0]       op_sel,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             cnt_clr,
   output logic             out_valid,
   output logic [WIDTH-1:0] ab_out,
   output logic             xor_out,
   output logic [CNT_W-1:0] odd_cnt,
   output logic             odd_sat
);

   // Handshake: in_valid qualifies a_in/b_in/op_sel for exactly one cycle; there is
   // no ready, the pipeline shifts every clock and out_valid marks each new result.

   logic [WIDTH-1:0] op_result;
   logic [DEPTH-1:0] stg_valid;
   logic [WIDTH-1:0] stg_data [DEPTH];

   always_comb begin
      op_result = '0;
      case (op_sel)
         2'b00:   op_result = a_in & b_in;
         2'b01:   op_result = a_in | b_in;
         2'b10:   op_result = a_in ^ b_in;
         default: op_result = ~(a_in & b_in);
      endcase
   end

   // Data registers only load behind a valid, so the output holds the last result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stg_valid <= '0;
         for (int k = 0; k < DEPTH; k++) stg_data[k] <= '0;
      end else begin
         stg_valid[0] <= in_valid;
         if (in_valid) stg_data[0] <= op_result;
         for (int k = 1; k < DEPTH; k++) begin
            stg_valid[k] <= stg_valid[k-1];
            if (stg_valid[k-1]) stg_data[k] <= stg_data[k-1];
         end
      end
   end

   assign out_valid = stg_valid[DEPTH-1];
   assign ab_out    = stg_data[DEPTH-1];
   assign xor_out   = ^stg_data[DEPTH-1];
   assign odd_sat   = &odd_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         odd_cnt <= '0;
      end else if (cnt_clr) begin
         odd_cnt <= '0;
      end else if (out_valid && xor_out && !odd_sat) begin
         odd_cnt <= odd_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: tb/tb_syncvar_pipe.sv
// Bench for syncvar_pipe: three builds (DEPTH 2/3/1, CNT_W 8/2/8) share one stimulus
// stream and are checked against a cycle-indexed history model.
module tb_syncvar_pipe;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [1:0] op_sel;
   logic [7:0] a_in, b_in;
   logic       cnt_clr;

   logic       ov  [3];
   logic [7:0] ab  [3];
   logic       xo  [3];
   logic [7:0] cnt [3];
   logic       sat [3];
   logic [1:0] cnt_small;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   syncvar_pipe #(.WIDTH(8), .DEPTH(2), .CNT_W(8)) u_d2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .op_sel(op_sel), .a_in(a_in), .b_in(b_in),
      .cnt_clr(cnt_clr), .out_valid(ov[0]), .ab_out(ab[0]), .xor_out(xo[0]),
      .odd_cnt(cnt[0]), .odd_sat(sat[0]));

   syncvar_pipe #(.WIDTH(8), .DEPTH(3), .CNT_W(2)) u_d3 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .op_sel(op_sel), .a_in(a_in), .b_in(b_in),
      .cnt_clr(cnt_clr), .out_valid(ov[1]), .ab_out(ab[1]), .xor_out(xo[1]),
      .odd_cnt(cnt_small), .odd_sat(sat[1]));

   syncvar_pipe #(.WIDTH(8), .DEPTH(1), .CNT_W(8)) u_d1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .op_sel(op_sel), .a_in(a_in), .b_in(b_in),
      .cnt_clr(cnt_clr), .out_valid(ov[2]), .ab_out(ab[2]), .xor_out(xo[2]),
      .odd_cnt(cnt[2]), .odd_sat(sat[2]));

   assign cnt[1] = {6'd0, cnt_small};

   // Reference model: every clock edge gets one history entry; an instance of depth D
   // shows the entry from D edges ago, and its data is the newest valid entry up to then.
   int         dep  [3] = '{2, 3, 1};
   int         cmax [3] = '{255, 3, 255};
   int         exp_cnt [3];
   logic       hist_v [4096];
   logic [7:0] hist_d [4096];
   int         cyc = 0;
   int         rst_mark = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [7:0] ref_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         2'd0:    return a & b;
         2'd1:    return a | b;
         2'd2:    return a ^ b;
         default: return ~(a & b);
      endcase
   endfunction

   task automatic model_out(input int k, output logic v, output logic [7:0] d);
      int idx;
      idx = cyc - dep[k];
      v = 1'b0;
      d = 8'h00;
      if (idx >= rst_mark) begin
         v = hist_v[idx];
         for (int j = idx; j >= rst_mark; j--) begin
            if (hist_v[j]) begin
               d = hist_d[j];
               break;
            end
         end
      end
   endtask

   task automatic check_all();
      logic       v;
      logic [7:0] d;
      for (int k = 0; k < 3; k++) begin
         model_out(k, v, d);
         check_val($sformatf("i%0d_out_valid", k), {31'd0, ov[k]}, {31'd0, v});
         check_val($sformatf("i%0d_ab_out", k), {24'd0, ab[k]}, {24'd0, d});
         check_val($sformatf("i%0d_xor_out", k), {31'd0, xo[k]}, {31'd0, ^d});
         check_val($sformatf("i%0d_odd_cnt", k), {24'd0, cnt[k]}, exp_cnt[k]);
         check_val($sformatf("i%0d_odd_sat", k), {31'd0, sat[k]}, {31'd0, exp_cnt[k] == cmax[k]});
      end
   endtask

   task automatic step(input logic v, input logic [1:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic clr);
      logic       pv;
      logic [7:0] pd;
      in_valid = v;
      op_sel   = op;
      a_in     = a;
      b_in     = b;
      cnt_clr  = clr;
      @(posedge clk);
      for (int k = 0; k < 3; k++) begin
         model_out(k, pv, pd);
         if (clr) exp_cnt[k] = 0;
         else if (pv && (^pd) && exp_cnt[k] < cmax[k]) exp_cnt[k]++;
      end
      hist_v[cyc] = v;
      hist_d[cyc] = ref_op(op, a, b);
      cyc++;
      @(negedge clk);
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 2'd0, 8'h00, 8'h00, 1'b0);
   endtask

   // Called at a negedge: reset is asserted between edges so its effect must be immediate.
   task automatic do_reset();
      in_valid = 1'b0;
      cnt_clr  = 1'b0;
      rst      = 1'b1;
      for (int k = 0; k < 3; k++) exp_cnt[k] = 0;
      rst_mark = cyc;
      #1;
      check_all();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_all();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      op_sel = 2'd0;
      a_in = 8'h00;
      b_in = 8'h00;
      cnt_clr = 1'b0;
      for (int i = 0; i < 4096; i++) begin
         hist_v[i] = 1'b0;
         hist_d[i] = 8'h00;
      end
      for (int k = 0; k < 3; k++) exp_cnt[k] = 0;
      #1;
      check_all();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_all();
      rst = 1'b0;

      // Single AND result, then fixed-value checks on the DEPTH=2 and DEPTH=1 builds.
      step(1'b1, 2'd0, 8'hF0, 8'h3C, 1'b0);
      check_val("d1_case1_valid", {31'd0, ov[2]}, 32'd1);
      check_val("d1_case1_ab", {24'd0, ab[2]}, 32'h30);
      step(1'b0, 2'd0, 8'h00, 8'h00, 1'b0);
      check_val("d2_case1_valid", {31'd0, ov[0]}, 32'd1);
      check_val("d2_case1_ab", {24'd0, ab[0]}, 32'h30);
      check_val("d2_case1_cnt", {24'd0, cnt[0]}, 32'd0);
      idle(2);

      // One input per op, back to back.
      for (int op = 0; op < 4; op++) step(1'b1, op[1:0], 8'h0F, 8'h01, 1'b0);
      idle(3);
      check_val("d2_ops_cnt", {24'd0, cnt[0]}, 32'd3);

      // Bubble between two valid inputs.
      step(1'b1, 2'd1, 8'h12, 8'h40, 1'b0);
      step(1'b0, 2'd2, 8'hFF, 8'hFF, 1'b0);
      step(1'b1, 2'd2, 8'hA5, 8'h0F, 1'b0);
      idle(3);

      // Saturation of the 2-bit counter, then clear against a same-cycle odd result.
      do_reset();
      for (int i = 0; i < 5; i++) step(1'b1, 2'd1, 8'h01, 8'h00, 1'b0);
      idle(2);
      check_val("d3_sat_cnt", {24'd0, cnt[1]}, 32'd3);
      check_val("d3_sat_flag", {31'd0, sat[1]}, 32'd1);
      step(1'b1, 2'd1, 8'h01, 8'h00, 1'b0);
      idle(1);
      step(1'b0, 2'd0, 8'h00, 8'h00, 1'b1);
      check_val("d3_clr_cnt", {24'd0, cnt[1]}, 32'd0);
      idle(2);

      // Reset with results still in flight.
      step(1'b1, 2'd3, 8'h33, 8'h55, 1'b0);
      step(1'b1, 2'd2, 8'h07, 8'h01, 1'b0);
      do_reset();
      idle(4);

      // Randomized traffic with occasional clears and resets.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 59) == 0) do_reset();
         step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 8'($urandom),
              8'($urandom), $urandom_range(0, 15) == 0);
      end
      idle(4);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
